alu_seq: RTL
============

// Module: alu_seq
// PURPOSE
//  Parametrised multi-cycle successor to the 8-bit combinational CPU ALU.
//  Adds SUB, iterative MUL (shift-add), logical left shift and arithmetic right shift.
//  Adds a START/BUSY/DONE handshake, registered outputs and CARRY/ZERO flags.
//  Sits between the register file read ports and the writeback mux. The control
//  unit stalls the PC while BUSY is high.
// PARAMETERS
//  WIDTH   8   operand/result width in bits (>=2)
//  SHW     $clog2(WIDTH)   shift-amount width (localparam, derived)
// PORTS
//  CLK        in   1      clock; all state changes on rising edge
//  RESET      in   1      synchronous, active-high reset
//  START      in   1      request; sampled only when BUSY=0
//  SELECT     in   3      opcode, sampled with START
//  DATA1      in   WIDTH  operand A, sampled with START
//  DATA2      in   WIDTH  operand B (shift amount = DATA2[SHW-1:0]), sampled with START
//  RESULT     out  WIDTH  registered result (MUL: low half)
//  RESULT_HI  out  WIDTH  MUL high half; 0 for all other ops
//  CARRY      out  1      ADD carry-out / SUB no-borrow (A>=B unsigned); 0 otherwise
//  ZERO       out  1      (RESULT==0), derived from RESULT register
//  BUSY       out  1      op in progress; START ignored
//  DONE       out  1      one-cycle pulse: RESULT/RESULT_HI/CARRY valid this cycle
// BEHAVIOUR
//  Opcodes: 000 FWD(B) 001 ADD 010 AND 011 OR 100 SUB(A-B) 101 MUL(unsigned) 110 SLL(A<<sh) 111 SRA(A>>>sh)
//  Reset (sync, highest priority, any state): FSM->IDLE, RESULT=0, RESULT_HI=0, CARRY=0, BUSY=0, DONE=0 (ZERO=1).
//  FSM: IDLE, MUL, SHIFT.
//   IDLE & START & op in {FWD,ADD,AND,OR,SUB}: result registered at same edge, DONE=1 next cycle; stay IDLE. Latency 1.
//   IDLE & START & MUL: load acc=0, mcand=A, mplier=B, cnt=WIDTH; ->MUL; BUSY=1.
//   MUL: one shift-add step per edge; after WIDTH steps write {RESULT_HI,RESULT}=A*B (2*WIDTH bits), DONE=1, BUSY=0, ->IDLE. Latency WIDTH+1.
//   IDLE & START & SLL/SRA: sh=B[SHW-1:0]. sh==0: RESULT=A, latency 1, stay IDLE.
//    else load A, cnt=sh, ->SHIFT: one bit per edge (SRA replicates MSB); after sh steps RESULT written, DONE=1, ->IDLE. Latency sh+1.
//   B bits above SHW are ignored for shifts.
//  DONE asserted exactly one cycle per accepted START; deasserted otherwise.
//  RESULT/RESULT_HI/CARRY hold their last value until the next completion, even while BUSY.
//  START in the DONE cycle (BUSY=0) is accepted: back-to-back ops, no bubble.
//  START while BUSY: ignored, no queuing; operands and opcode held internally, so input changes are harmless.
//  ADD/SUB: WIDTH+1-bit arithmetic, wrap modulo 2^WIDTH; CARRY = bit WIDTH (SUB via A+~B+1).
//  RESET asserted mid-MUL/SHIFT: op aborted, no DONE, outputs to reset values next edge.
// STRUCTURE
//  alu_pkg: opcode localparams (OP_FWD..OP_SRA) and FSM state encodings.
//  One sub-module: alu_iter_unit, the shared shift/shift-add datapath (acc, operand regs, counter).
//   Inputs: load, mode, step. Outputs: last, result.
//  alu_seq contains the FSM, the single-cycle ops, and the output registers.
// TESTING (WIDTH=8)
//  RESET high 2 cycles mid-MUL (after 3 steps) -> no DONE. RESULT=0, RESULT_HI=0, BUSY=0, ZERO=1.
//  ADD 0xF0+0x20 -> 1 cycle later DONE=1, RESULT=0x10, CARRY=1. SUB 0x05-0x05 -> RESULT=0, ZERO=1, CARRY=1.
//  MUL 0xFF*0xFF -> BUSY 8 cycles, DONE on 9th, {RESULT_HI,RESULT}=0xFE01; START pulses while BUSY ignored.
//  SRA 0x80 by DATA2=0x0B (sh=3) -> DONE after 4 cycles, RESULT=0xF0. SLL 0x81 by 0 -> latency 1, RESULT=0x81.
//  Back-to-back: MUL 3*4, START AND 0x0F&0x3C in its DONE cycle -> RESULT=0x0C then 0x0C, two DONE pulses.
//  Random op/operand stream vs reference model, checking latency formula and one DONE per accepted START.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode, FSM-state and iterative-mode encodings for the sequential ALU.
package alu_pkg;

   localparam logic [2:0] OP_FWD = 3'b000;
   localparam logic [2:0] OP_ADD = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_SUB = 3'b100;
   localparam logic [2:0] OP_MUL = 3'b101;
   localparam logic [2:0] OP_SLL = 3'b110;
   localparam logic [2:0] OP_SRA = 3'b111;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_MUL   = 2'd1;
   localparam logic [1:0] ST_SHIFT = 2'd2;

   localparam logic [1:0] MODE_MUL = 2'd0;
   localparam logic [1:0] MODE_SLL = 2'd1;
   localparam logic [1:0] MODE_SRA = 2'd2;

endpackage

// File: rtl/alu_iter_unit.sv
// Shared multi-cycle datapath: shift-add multiplier and one-bit-per-step shifter.
// result is the post-step value, so the owner can capture it on the final step edge.
module alu_iter_unit
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 load,
   input  logic [1:0]           mode,
   input  logic                 step,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 last,
   output logic [2*WIDTH-1:0]   result
);

   localparam int SHW = $clog2(WIDTH);
   localparam int CW  = $clog2(WIDTH + 1);

   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;
   logic [CW-1:0]    cnt;
   logic [1:0]       mode_r;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] acc_n;
   logic [WIDTH-1:0] mplier_n;

   // Multiply: {acc,mplier} shifts right as a 2*WIDTH product register.
   always_comb begin
      sum      = {1'b0, acc} + ({1'b0, mcand} & {(WIDTH+1){mplier[0]}});
      acc_n    = acc;
      mplier_n = mplier;
      case (mode_r)
         MODE_MUL: begin
            acc_n    = sum[WIDTH:1];
            mplier_n = {sum[0], mplier[WIDTH-1:1]};
         end
         MODE_SLL: acc_n = {acc[WIDTH-2:0], 1'b0};
         MODE_SRA: acc_n = {acc[WIDTH-1], acc[WIDTH-1:1]};
         default:  acc_n = acc;
      endcase
   end

   assign last   = (cnt == CW'(1));
   assign result = (mode_r == MODE_MUL) ? {acc_n, mplier_n} : {{WIDTH{1'b0}}, acc_n};

   always_ff @(posedge clk) begin
      if (load) begin
         mode_r <= mode;
         if (mode == MODE_MUL) begin
            cnt    <= CW'(WIDTH);
            acc    <= '0;
            mcand  <= a;
            mplier <= b;
         end else begin
            cnt    <= CW'(b[SHW-1:0]);
            acc    <= a;
            mcand  <= '0;
            mplier <= '0;
         end
      end else if (step) begin
         acc    <= acc_n;
         mplier <= mplier_n;
         cnt    <= cnt - CW'(1);
      end
   end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU with START/BUSY/DONE handshake: single-cycle logic/arith ops,
// iterative MUL and multi-cycle shifts on a shared datapath, registered outputs.
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             START,
   input  logic [2:0]       SELECT,
   input  logic [WIDTH-1:0] DATA1,
   input  logic [WIDTH-1:0] DATA2,
   output logic [WIDTH-1:0] RESULT,
   output logic [WIDTH-1:0] RESULT_HI,
   output logic             CARRY,
   output logic             ZERO,
   output logic             BUSY,
   output logic             DONE
);

   localparam int SHW = $clog2(WIDTH);

   logic [1:0]           state;
   logic                 accept;
   logic                 is_mul;
   logic                 is_shift;
   logic                 shift_nz;
   logic                 load;
   logic                 step;
   logic                 last;
   logic [1:0]           mode;
   logic [2*WIDTH-1:0]   iter_result;
   logic [WIDTH:0]       single;

   // Bit WIDTH carries ADD carry-out / SUB no-borrow; zero-amount shifts pass A.
   function automatic logic [WIDTH:0] single_op(input logic [2:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
      case (op)
         OP_FWD:  return {1'b0, b};
         OP_ADD:  return {1'b0, a} + {1'b0, b};
         OP_AND:  return {1'b0, a & b};
         OP_OR:   return {1'b0, a | b};
         OP_SUB:  return {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
         default: return {1'b0, a};
      endcase
   endfunction

   assign accept   = START && (state == ST_IDLE);
   assign is_mul   = (SELECT == OP_MUL);
   assign is_shift = (SELECT == OP_SLL) || (SELECT == OP_SRA);
   assign shift_nz = (DATA2[SHW-1:0] != '0);
   assign load     = accept && (is_mul || (is_shift && shift_nz));
   assign mode     = is_mul ? MODE_MUL : ((SELECT == OP_SLL) ? MODE_SLL : MODE_SRA);
   assign step     = (state != ST_IDLE);
   assign single   = single_op(SELECT, DATA1, DATA2);

   alu_iter_unit #(.WIDTH(WIDTH)) u_iter (
      .clk    (CLK),
      .load   (load),
      .mode   (mode),
      .step   (step),
      .a      (DATA1),
      .b      (DATA2),
      .last   (last),
      .result (iter_result)
   );

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state     <= ST_IDLE;
         RESULT    <= '0;
         RESULT_HI <= '0;
         CARRY     <= 1'b0;
         DONE      <= 1'b0;
      end else begin
         DONE <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  if (is_mul) begin
                     state <= ST_MUL;
                  end else if (is_shift && shift_nz) begin
                     state <= ST_SHIFT;
                  end else begin
                     {CARRY, RESULT} <= single;
                     RESULT_HI       <= '0;
                     DONE            <= 1'b1;
                  end
               end
            end
            ST_MUL: begin
               if (last) begin
                  {RESULT_HI, RESULT} <= iter_result;
                  CARRY               <= 1'b0;
                  DONE                <= 1'b1;
                  state               <= ST_IDLE;
               end
            end
            ST_SHIFT: begin
               if (last) begin
                  RESULT    <= iter_result[WIDTH-1:0];
                  RESULT_HI <= '0;
                  CARRY     <= 1'b0;
                  DONE      <= 1'b1;
                  state     <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign BUSY = (state != ST_IDLE);
   assign ZERO = (RESULT == '0);

endmodule
